// File: rtl/pmem_pkg.sv
// pmem_pkg: shared beat/line types, burst geometry and FSM states for the pmem burst responder.
package pmem_pkg;
  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;
  typedef logic [BEAT_W-1:0] pmem_beat_t;
  typedef logic [LINE_W-1:0] pmem_line_t;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_state_t;
endpackage

// File: rtl/pmem_line_ram.sv
// pmem_line_ram: LINES x 4 x 64 beat-addressed storage, synchronous write, combinational read, no reset.
module pmem_line_ram
  import pmem_pkg::*;
#(
  parameter int LINES = 256,
  parameter int AW    = $clog2(LINES) + 2
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  pmem_beat_t    i_wdata,
  output pmem_beat_t    o_rdata
);
  pmem_beat_t r_mem [LINES*BEATS];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: 4-beat x 64-bit line memory responder with programmable access latency.
// Optional PMEM_PROTO_CHECK_EN enables the sticky proto_err flag and simulation assertions.
module pmem_burst_responder
  import pmem_pkg::*;
#(
  parameter int LINES   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  pmem_beat_t  pmem_wdata,
  output pmem_beat_t  pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err
);
  localparam int LW = $clog2(LINES);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  pmem_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_beat;
  logic          r_wr;
  logic [LW-1:0] r_line;
  logic          r_resp;
  pmem_beat_t    r_rdata;
  logic          w_accept;
  logic          w_rd_load;
  logic [1:0]    w_ram_beat;
  pmem_beat_t    w_ram_rdata;
  logic          w_unused;
  assign w_unused = ^{pmem_address[31:OFFSET_BITS+LW], pmem_address[OFFSET_BITS-1:0]};
`ifdef PMEM_PROTO_CHECK_EN
  logic w_viol;
  logic r_err;
  assign w_accept = pmem_read ^ pmem_write;
  assign w_viol   = (r_state == IDLE && pmem_read && pmem_write) ||
                    ((r_state == WAIT || r_state == BURST) &&
                     (r_wr ? (!pmem_write || pmem_read) : (!pmem_read || pmem_write)));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_err <= 1'b0;
    else if (w_viol) r_err <= 1'b1;
  assign proto_err = r_err;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (reset_n) assert (!w_viol) else $warning("pmem protocol violation at state %s", r_state.name());
`endif
`else
  assign w_accept  = pmem_read | pmem_write;
  assign proto_err = 1'b0;
`endif
  // Reads prefetch the next beat so the registered output lines up with its resp cycle.
  assign w_ram_beat = (r_wr || r_state != BURST) ? r_beat : r_beat + 2'd1;
  assign w_rd_load  = !r_wr && ((r_state == WAIT && r_cnt == '0) || (r_state == BURST && r_beat != 2'd3));
  pmem_line_ram #(.LINES(LINES)) u_ram (
    .clk     (clk),
    .i_we    (r_state == BURST && r_wr),
    .i_addr  ({r_line, w_ram_beat}),
    .i_wdata (pmem_wdata),
    .o_rdata (w_ram_rdata)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_wr    <= 1'b0;
      r_line  <= '0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_accept) begin
            r_state <= WAIT;
            r_cnt   <= CW'(LATENCY - 1);
            r_wr    <= pmem_write;
            r_line  <= pmem_address[OFFSET_BITS +: LW];
          end
        WAIT:
          if (r_cnt == '0) begin
            r_state <= BURST;
            r_beat  <= '0;
            r_resp  <= 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        BURST: begin
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) begin
            r_state <= DONE;
            r_resp  <= 1'b0;
          end
        end
        DONE: if (!pmem_read && !pmem_write) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_rd_load) r_rdata <= w_ram_rdata;
    end
  assign pmem_resp  = r_resp;
  assign pmem_rdata = r_rdata;
endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb_pmem_burst_responder: random + directed bursts against a line-array/timeline model of the responder.
module tb_pmem_burst_responder;
  localparam int LAT = 4;
  localparam int LW  = 8;
  logic        clk = 0, reset_n = 0, rd = 0, wr = 0;
  logic [31:0] addr = 0;
  logic [63:0] wdata = 0, rdata;
  logic        resp, err;
  logic        rd1 = 0, wr1 = 0;
  logic [31:0] addr1 = 0;
  logic [63:0] wdata1 = 0, rdata1;
  logic        resp1, err1;
  always #5 clk = ~clk;
  pmem_burst_responder #(.LINES(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd), .pmem_write(wr), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_rdata(rdata), .pmem_resp(resp), .proto_err(err));
  pmem_burst_responder #(.LINES(4), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1),
    .pmem_wdata(wdata1), .pmem_rdata(rdata1), .pmem_resp(resp1), .proto_err(err1));
  int checks = 0, failures = 0, cyc = 0, first_resp = -1, err_cyc = -1;
  bit chk_en = 0, er;
  logic [63:0] mem [int];
  bit exp_r [int];
  logic [63:0] exp_d [int];
  logic [63:0] m_last = 0;
  int wl [$];
  function automatic int lidx(logic [31:0] a);
    return int'(a[5 +: LW]);
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // Timeline model: exp_r marks resp cycles, exp_d the read beats; rdata otherwise holds the last read beat.
  always @(negedge clk) if (chk_en) begin
    er = exp_r.exists(cyc);
    if (er && exp_d.exists(cyc)) m_last = exp_d[cyc];
    if (er && first_resp < 0) first_resp = cyc;
    chk("resp", {63'b0, resp}, {63'b0, er});
    if (!er || exp_d.exists(cyc)) chk("rdata", rdata, m_last);
    chk("proto_err", {63'b0, err}, {63'b0, err_cyc >= 0 && cyc >= err_cyc});
  end
  task automatic xfer(input bit w, input logic [31:0] a, input int hold, input bit both,
                      input logic [63:0] wb [4], output int acc);
    int li, k0;
    li = lidx(a);
    rd = !w || both;
    wr = w || both;
    addr = a;
    acc = cyc + 1;
    k0 = acc + LAT;
    first_resp = -1;
    for (int b = 0; b < 4; b++) begin
      exp_r[k0+b] = 1'b1;
      if (!w && !both) exp_d[k0+b] = mem[li*4+b];
    end
    for (int b = 0; b < 4; b++) begin
      while (cyc != k0 + b) @(negedge clk);
      if (w || both) begin
        wdata = wb[b];
        mem[li*4+b] = wb[b];
      end
    end
    if (w || both) wl.push_back(li);
    while (cyc != k0 + 4 + hold) @(negedge clk);
    rd = 0;
    wr = 0;
    @(negedge clk);
  endtask
  task automatic hard_reset();
    chk_en = 0;
    reset_n = 0;
    #1;
    chk("rst_resp", {63'b0, resp}, 64'd0);
    chk("rst_err", {63'b0, err}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rd = 0;
    wr = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    exp_r.delete();
    exp_d.delete();
    m_last = 0;
    err_cyc = -1;
    chk_en = 1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] wb [4];
    logic [31:0] a;
    int acc, li, k0;
    repeat (3) @(negedge clk);
    hard_reset();
    @(negedge clk);
    // Write then read 0x40.
    wb = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    xfer(1, 32'h0000_0040, 0, 0, wb, acc);
    chk("wr_lat", first_resp - acc, 64'd4);
    chk("model_beat0", mem[2*4+0], 64'h1111_1111_1111_1111);
    xfer(0, 32'h0000_0040, 0, 0, wb, acc);
    chk("rd_lat", first_resp - acc, 64'd4);
    chk("rd_last_beat", m_last, 64'h4444_4444_4444_4444);
    // Offset ignored and aliasing.
    wb = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3};
    xfer(1, 32'h0000_0020, 0, 0, wb, acc);
    chk("alias_idx", lidx(32'h0000_2020), 64'd1);
    xfer(0, 32'h0000_003C, 0, 0, wb, acc);
    xfer(0, 32'h0000_2020, 0, 0, wb, acc);
    chk("alias_last", m_last, 64'hA3A3_A3A3_A3A3_A3A3);
    // Held request then immediate next request.
    xfer(0, 32'h0000_0040, 3, 0, wb, acc);
    xfer(0, 32'h0000_0020, 0, 0, wb, acc);
    chk("held_next_lat", first_resp - acc, 64'd4);
`ifdef PMEM_PROTO_CHECK_EN
    rd = 1;
    wr = 1;
    err_cyc = cyc + 1;
    repeat (3) @(negedge clk);
    rd = 0;
    wr = 0;
    repeat (2) @(negedge clk);
    chk("err_sticky", {63'b0, err}, 64'd1);
    hard_reset();
    @(negedge clk);
`else
    wb = '{64'h5, 64'h6, 64'h7, 64'h8};
    xfer(1, 32'h0000_0060, 0, 1, wb, acc);
    chk("both_as_write", mem[3*4+2], 64'h7);
`endif
    // Reset mid-burst on a write to line 1.
    rd = 0;
    wr = 1;
    addr = 32'h0000_0020;
    li = 1;
    k0 = cyc + 1 + LAT;
    exp_r[k0] = 1'b1;
    exp_r[k0+1] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      while (cyc != k0 + b) @(negedge clk);
      wdata = 64'hB0B0_0000_0000_0000 + 64'(b);
      mem[li*4+b] = wdata;
    end
    @(posedge clk);
    #1;
    chk_en = 0;
    chk("pre_rst_resp", {63'b0, resp}, 64'd1);
    hard_reset();
    @(negedge clk);
    chk("mid_model_b1", mem[4+1], 64'hB0B0_0000_0000_0001);
    chk("mid_model_b2", mem[4+2], 64'hA2A2_A2A2_A2A2_A2A2);
    xfer(0, 32'h0000_0020, 0, 0, wb, acc);
    chk("mid_last", m_last, 64'hA3A3_A3A3_A3A3_A3A3);
    // Random protocol-compliant traffic.
    for (int t = 0; t < 40; t++) begin
      bit w;
      w = ($urandom_range(0, 1) == 1);
      a = $urandom;
      if (!w) a[12:5] = 8'(wl[$urandom_range(0, wl.size() - 1)]);
      for (int b = 0; b < 4; b++) wb[b] = {$urandom, $urandom};
      xfer(w, a, $urandom_range(0, 2), 0, wb, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    // LATENCY=1 instance: resp on the cycle after acceptance, 4 contiguous beats.
    chk_en = 0;
    wr1 = 1;
    addr1 = 32'h0000_0040;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l1_wr_resp", {63'b0, resp1}, {63'b0, i >= 1 && i <= 4});
      if (i >= 1 && i <= 4) wdata1 = 64'hC0C0_0000_0000_0000 + 64'(i - 1);
      if (i == 5) wr1 = 0;
    end
    @(negedge clk);
    rd1 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("l1_rd_resp", {63'b0, resp1}, {63'b0, i >= 1 && i <= 4});
      if (i >= 1 && i <= 4) chk("l1_rdata", rdata1, 64'hC0C0_0000_0000_0000 + 64'(i - 1));
      if (i == 5) rd1 = 0;
    end
    chk("l1_err", {63'b0, err1}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
